csr_commit_ctrl: RTL and testbench
==================================

Name: csr_commit_ctrl

Overview:
Writeback-stage commit sequencer for the CSR file. It accepts one committing instruction per cycle and priority-encodes its exception flags together with the pending interrupt. It drives the CSR file's write, exception and ertn ports. On exception, ertn, or a control-CSR write it redirects the frontend, flushes the pipeline and drains for a fixed period.

Parameters:
DRAIN_CYCLES, 2, cycles after redirect acceptance during which commits are blocked and flush stays high (1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
wb_valid  in  1  instruction presented for commit
wb_ready  out  1  commit accepted this cycle when wb_valid&&wb_ready
wb_pc  in  32  PC of committing instruction
wb_badv  in  32  faulting data address
wb_exc  in  6  {adem, ale, brk, sys, ine, adef} exception flags
wb_ertn  in  1  instruction is ertn
wb_csr_op  in  2  0 none, 1 csrrd, 2 csrwr, 3 csrxchg
wb_csr_num  in  14  CSR number
wb_csr_wdata  in  32  rd value
wb_csr_mask  in  32  rj value (xchg mask)
csr_result  out  32  read data to register file (= csr_rdata)
csr_num, csr_we, csr_wnum, csr_wmask, csr_wdata  out  14/1/14/32/32  CSR file access port
wb_ex, wb_ecode, wb_esubcode, wb_ex_pc, wb_ex_badv  out  1/6/9/32/32  CSR file exception port
ertn_flush  out  1  CSR file ertn port
csr_rdata  in  32  CSR file read data
has_int, ex_entry, ex_ra  in  1/32/32  from CSR file
flush  out  1  pipeline flush
redirect_valid  out  1  frontend redirect request
redirect_pc  out  32  redirect target (registered)
redirect_ready  in  1  frontend accepts redirect

Behaviour:
- FSM states: IDLE, REDIRECT, DRAIN. Async reset sets IDLE, drain counter 0, redirect_pc 0, redirect_valid 0 and flush 0. All CSR-port strobes are 0 outside a commit cycle. wb_ready=1 only in IDLE.
- Commit cycle (IDLE, wb_valid):
  - exc = has_int | (|wb_exc).
  - Priority: INT(0x0) > ADEF(0x8,sub 0) > INE(0xD) > SYS(0xB) > BRK(0xC) > ALE(0x9) > ADEM(0x8,sub 1).
  - wb_ex, wb_ecode and wb_esubcode are combinational in the same cycle. wb_ex_pc=wb_pc and wb_ex_badv=wb_badv.
- Exception commit: csr_we=0 and ertn_flush=0 (exception overrides ertn and CSR write). Latch redirect_pc<=ex_entry, go to REDIRECT.
- ertn commit without exception: ertn_flush=1 for one cycle. Latch redirect_pc<=ex_ra, go to REDIRECT.
- CSR commit without exception:
  - csr_num=wb_csr_num, csr_result=csr_rdata (combinational, same cycle).
  - op 2 or 3: csr_we=1 for one cycle, csr_wnum=wb_csr_num, csr_wdata=wb_csr_wdata. csr_wmask=32'hffffffff for op 2, wb_csr_mask for op 3.
  - Write to CRMD, ECFG, ESTAT, TCFG or TICLR: redirect_pc<=wb_pc+4 (mod 2^32), go to REDIRECT (refetch so the new IE/LIE takes effect). Other writes stay in IDLE.
- Ordinary commit: stay in IDLE, no strobes.
- REDIRECT: redirect_valid=1 and flush=1; redirect_pc stays stable. On redirect_ready, go to DRAIN and load counter=DRAIN_CYCLES-1.
- DRAIN: flush=1, redirect_valid=0. Counter decrements each cycle; at 0 return to IDLE. Total blocked cycles after acceptance equal DRAIN_CYCLES.
- has_int is sampled only in commit cycles. has_int pulses outside IDLE are ignored; level interrupts are taken at the next commit.
- Asserting reset in any state immediately forces IDLE; a pending redirect is dropped.

Optional Feature:
CSR_COMMIT_CTRL_EXC_CNT_EN:
- Defined: adds outputs exc_count[31:0] and ertn_count[31:0]. They reset to 0 and increment (wrapping) on each exception commit and each ertn commit respectively.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared header csr_head.v: CSR numbers, ECODE_*/ESUBCODE_* values, new CSR_OP_NONE/RD/WR/XCHG, and FSM state encodings CTRL_IDLE/REDIRECT/DRAIN.
- One combinational sub-module, exc_prio_enc: inputs wb_exc and has_int; outputs exc, ecode and esubcode.

Test Plan:
- csrwr SAVE0 wdata=0x12345678 → csr_we=1 one cycle, wmask=0xffffffff, stays IDLE, wb_ready=1 next cycle.
- csrxchg CRMD wdata=0x4, mask=0x4 at pc 0x1c000100 → csr_we=1, wmask=0x4, redirect_pc=0x1c000104, redirect_valid held until redirect_ready.
- wb_exc={ale=1, ine=1}, ex_entry=0x1c008000 → wb_ecode=0xD (INE wins), no csr_we, redirect to 0x1c008000, flush high until DRAIN_CYCLES=2 cycles after ready.
- has_int=1 with ertn committing, ex_ra=0x1c000200 → wb_ecode=0x0, ertn_flush=0, redirect_pc=ex_entry.
- ertn alone, ex_ra=0x1c000200, redirect_ready held low 5 cycles → redirect_valid stays 1 and wb_ready stays 0 throughout, then DRAIN.
- reset asserted mid-REDIRECT → redirect_valid and flush drop at once, wb_ready=1 after release.

Source files
------------

// File: rtl/csr_commit_ctrl_pkg.sv
// Shared definitions for the CSR commit controller: CSR numbers,
// exception codes, CSR operation encodings and controller FSM states.
package csr_commit_ctrl_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;

  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

  localparam logic [1:0] CSR_OP_NONE = 2'd0;
  localparam logic [1:0] CSR_OP_RD   = 2'd1;
  localparam logic [1:0] CSR_OP_WR   = 2'd2;
  localparam logic [1:0] CSR_OP_XCHG = 2'd3;

  typedef enum logic [1:0] {
    CTRL_IDLE     = 2'd0,
    CTRL_REDIRECT = 2'd1,
    CTRL_DRAIN    = 2'd2
  } ctrl_state_e;

  // Writes to these CSRs can change interrupt enables, so the
  // following instructions must be refetched.
  function automatic logic is_ctrl_csr(input logic [13:0] num);
    return (num == CSR_CRMD) || (num == CSR_ECFG) || (num == CSR_ESTAT) ||
           (num == CSR_TCFG) || (num == CSR_TICLR);
  endfunction

endpackage

// File: rtl/csr_commit_ctrl_exc_prio_enc.sv
// Exception priority encoder: interrupt first, then the instruction
// exception flags {adem, ale, brk, sys, ine, adef} in fetch-to-memory order.
module exc_prio_enc
  import csr_commit_ctrl_pkg::*;
(
  input  logic [5:0] wb_exc,
  input  logic       has_int,
  output logic       exc,
  output logic [5:0] ecode,
  output logic [8:0] esubcode
);

  // Highest-priority pending cause selects the code.
  always_comb begin
    exc      = 1'b1;
    ecode    = ECODE_INT;
    esubcode = ESUBCODE_ADEF;
    if (has_int) begin
      ecode = ECODE_INT;
    end else if (wb_exc[0]) begin
      ecode    = ECODE_ADE;
      esubcode = ESUBCODE_ADEF;
    end else if (wb_exc[1]) begin
      ecode = ECODE_INE;
    end else if (wb_exc[2]) begin
      ecode = ECODE_SYS;
    end else if (wb_exc[3]) begin
      ecode = ECODE_BRK;
    end else if (wb_exc[4]) begin
      ecode = ECODE_ALE;
    end else if (wb_exc[5]) begin
      ecode    = ECODE_ADE;
      esubcode = ESUBCODE_ADEM;
    end else begin
      exc = 1'b0;
    end
  end

endmodule

// File: rtl/csr_commit_ctrl.sv
// Writeback commit sequencer for the CSR file. Drives CSR write,
// exception and ertn ports, and redirects/flushes/drains the pipeline
// after exceptions, ertn and control-CSR writes.
// Optional: CSR_COMMIT_CTRL_EXC_CNT_EN adds exception/ertn commit counters.
module csr_commit_ctrl
  import csr_commit_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badv,
  input  logic [5:0]  wb_exc,
  input  logic        wb_ertn,
  input  logic [1:0]  wb_csr_op,
  input  logic [13:0] wb_csr_num,
  input  logic [31:0] wb_csr_wdata,
  input  logic [31:0] wb_csr_mask,
  output logic [31:0] csr_result,
  output logic [13:0] csr_num,
  output logic        csr_we,
  output logic [13:0] csr_wnum,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wdata,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_ex_pc,
  output logic [31:0] wb_ex_badv,
  output logic        ertn_flush,
  input  logic [31:0] csr_rdata,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ex_ra,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
`ifdef CSR_COMMIT_CTRL_EXC_CNT_EN
  ,
  output logic [31:0] exc_count,
  output logic [31:0] ertn_count
`endif
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  ctrl_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rpc_q, rpc_d;
  logic        exc;
  logic        is_write;

  exc_prio_enc u_exc_prio_enc (
    .wb_exc   (wb_exc),
    .has_int  (has_int),
    .exc      (exc),
    .ecode    (wb_ecode),
    .esubcode (wb_esubcode)
  );

  assign is_write    = (wb_csr_op == CSR_OP_WR) || (wb_csr_op == CSR_OP_XCHG);
  assign csr_num     = wb_csr_num;
  assign csr_result  = csr_rdata;
  assign csr_wnum    = wb_csr_num;
  assign csr_wdata   = wb_csr_wdata;
  assign csr_wmask   = (wb_csr_op == CSR_OP_XCHG) ? wb_csr_mask : 32'hffff_ffff;
  assign wb_ex_pc    = wb_pc;
  assign wb_ex_badv  = wb_badv;
  assign redirect_pc = rpc_q;

  // Controller state, drain counter and redirect target registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CTRL_IDLE;
      cnt_q   <= 4'd0;
      rpc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpc_q   <= rpc_d;
    end
  end

  // Next-state logic and commit-cycle strobes; exception beats ertn beats CSR write.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rpc_d          = rpc_q;
    wb_ready       = 1'b0;
    wb_ex          = 1'b0;
    csr_we         = 1'b0;
    ertn_flush     = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    case (state_q)
      CTRL_IDLE: begin
        wb_ready = 1'b1;
        if (wb_valid) begin
          if (exc) begin
            wb_ex   = 1'b1;
            rpc_d   = ex_entry;
            state_d = CTRL_REDIRECT;
          end else if (wb_ertn) begin
            ertn_flush = 1'b1;
            rpc_d      = ex_ra;
            state_d    = CTRL_REDIRECT;
          end else if (is_write) begin
            csr_we = 1'b1;
            if (is_ctrl_csr(wb_csr_num)) begin
              rpc_d   = wb_pc + 32'd4;
              state_d = CTRL_REDIRECT;
            end
          end
        end
      end
      CTRL_REDIRECT: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        if (redirect_ready) begin
          cnt_d   = DRAIN_LOAD;
          state_d = CTRL_DRAIN;
        end
      end
      CTRL_DRAIN: begin
        flush = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = CTRL_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = CTRL_IDLE;
      end
    endcase
  end

`ifdef CSR_COMMIT_CTRL_EXC_CNT_EN
  // Wrapping counters of exception and ertn commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_count  <= 32'd0;
      ertn_count <= 32'd0;
    end else begin
      if (wb_ex)      exc_count  <= exc_count + 32'd1;
      if (ertn_flush) ertn_count <= ertn_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Directed self-checking bench for csr_commit_ctrl (DRAIN_CYCLES = 2).
module tb_csr_commit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_pc, wb_badv;
  logic [5:0]  wb_exc;
  logic        wb_ertn;
  logic [1:0]  wb_csr_op;
  logic [13:0] wb_csr_num;
  logic [31:0] wb_csr_wdata, wb_csr_mask;
  logic [31:0] csr_result;
  logic [13:0] csr_num, csr_wnum;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wdata;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_ex_pc, wb_ex_badv;
  logic        ertn_flush;
  logic [31:0] csr_rdata;
  logic        has_int;
  logic [31:0] ex_entry, ex_ra;
  logic        flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
`ifdef CSR_COMMIT_CTRL_EXC_CNT_EN
  logic [31:0] exc_count, ertn_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  csr_commit_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_pc          (wb_pc),
    .wb_badv        (wb_badv),
    .wb_exc         (wb_exc),
    .wb_ertn        (wb_ertn),
    .wb_csr_op      (wb_csr_op),
    .wb_csr_num     (wb_csr_num),
    .wb_csr_wdata   (wb_csr_wdata),
    .wb_csr_mask    (wb_csr_mask),
    .csr_result     (csr_result),
    .csr_num        (csr_num),
    .csr_we         (csr_we),
    .csr_wnum       (csr_wnum),
    .csr_wmask      (csr_wmask),
    .csr_wdata      (csr_wdata),
    .wb_ex          (wb_ex),
    .wb_ecode       (wb_ecode),
    .wb_esubcode    (wb_esubcode),
    .wb_ex_pc       (wb_ex_pc),
    .wb_ex_badv     (wb_ex_badv),
    .ertn_flush     (ertn_flush),
    .csr_rdata      (csr_rdata),
    .has_int        (has_int),
    .ex_entry       (ex_entry),
    .ex_ra          (ex_ra),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
`ifdef CSR_COMMIT_CTRL_EXC_CNT_EN
    ,
    .exc_count      (exc_count),
    .ertn_count     (ertn_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Called at a sample point while in REDIRECT: accept, then two drain cycles.
  task automatic accept_and_drain(input string tag);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    sample();
    chk({tag, "_drain1_flush"}, flush, 1'b1);
    chk({tag, "_drain1_rv"}, redirect_valid, 1'b0);
    tick();
    sample();
    chk({tag, "_drain2_flush"}, flush, 1'b1);
    tick();
    sample();
    chk({tag, "_done_flush"}, flush, 1'b0);
    chk({tag, "_done_ready"}, wb_ready, 1'b1);
  endtask

  task automatic exc_case(input string tag, input logic [5:0] e,
                          input logic [5:0] code, input logic [8:0] sub);
    tick();
    wb_valid = 1'b1;
    wb_exc   = e;
    sample();
    chk({tag, "_ex"}, wb_ex, 1'b1);
    chk({tag, "_ecode"}, wb_ecode, code);
    chk({tag, "_esub"}, wb_esubcode, sub);
    tick();
    wb_valid = 1'b0;
    wb_exc   = 6'd0;
    sample();
    chk({tag, "_rv"}, redirect_valid, 1'b1);
    accept_and_drain(tag);
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; wb_pc = 32'd0; wb_badv = 32'd0; wb_exc = 6'd0;
    wb_ertn = 1'b0; wb_csr_op = 2'd0; wb_csr_num = 14'd0; wb_csr_wdata = 32'd0;
    wb_csr_mask = 32'd0; csr_rdata = 32'd0; has_int = 1'b0; ex_entry = 32'd0;
    ex_ra = 32'd0; redirect_ready = 1'b0;
    repeat (2) sample();
    chk("rst_ready", wb_ready, 1'b1);
    chk("rst_rv", redirect_valid, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_we", csr_we, 1'b0);
    tick();
    reset = 1'b0;

    // csrwr SAVE0: plain write, stays in IDLE
    wb_valid = 1'b1; wb_csr_op = 2'd2; wb_csr_num = 14'h030;
    wb_csr_wdata = 32'h1234_5678; wb_csr_mask = 32'hdead_beef;
    csr_rdata = 32'ha5a5_0f0f; wb_pc = 32'h1c00_0000;
    sample();
    chk("wr_we", csr_we, 1'b1);
    chk("wr_wmask", csr_wmask, 32'hffff_ffff);
    chk("wr_wnum", csr_wnum, 32'h30);
    chk("wr_wdata", csr_wdata, 32'h1234_5678);
    chk("wr_num", csr_num, 32'h30);
    chk("wr_result", csr_result, 32'ha5a5_0f0f);
    chk("wr_ex", wb_ex, 1'b0);
    tick();
    wb_valid = 1'b0; wb_csr_op = 2'd0;
    sample();
    chk("wr_we_off", csr_we, 1'b0);
    chk("wr_ready_next", wb_ready, 1'b1);
    chk("wr_no_flush", flush, 1'b0);

    // csrxchg CRMD: write then refetch at pc+4
    tick();
    wb_valid = 1'b1; wb_csr_op = 2'd3; wb_csr_num = 14'h000;
    wb_csr_wdata = 32'h4; wb_csr_mask = 32'h4; wb_pc = 32'h1c00_0100;
    sample();
    chk("xchg_we", csr_we, 1'b1);
    chk("xchg_wmask", csr_wmask, 32'h4);
    chk("xchg_wdata", csr_wdata, 32'h4);
    tick();
    wb_valid = 1'b0; wb_csr_op = 2'd0;
    sample();
    chk("xchg_rv", redirect_valid, 1'b1);
    chk("xchg_rpc", redirect_pc, 32'h1c00_0104);
    chk("xchg_flush", flush, 1'b1);
    chk("xchg_busy", wb_ready, 1'b0);
    chk("xchg_we_off", csr_we, 1'b0);
    tick();
    sample();
    chk("xchg_rv_hold", redirect_valid, 1'b1);
    accept_and_drain("xchg");

    // ALE + INE: INE wins, CSR write suppressed
    tick();
    wb_valid = 1'b1; wb_exc = 6'b010010; wb_csr_op = 2'd2; wb_csr_num = 14'h030;
    wb_pc = 32'h1c00_0300; wb_badv = 32'h0000_1234; ex_entry = 32'h1c00_8000;
    sample();
    chk("ine_ex", wb_ex, 1'b1);
    chk("ine_ecode", wb_ecode, 6'h0d);
    chk("ine_esub", wb_esubcode, 9'h0);
    chk("ine_we", csr_we, 1'b0);
    chk("ine_expc", wb_ex_pc, 32'h1c00_0300);
    chk("ine_badv", wb_ex_badv, 32'h0000_1234);
    tick();
    wb_valid = 1'b0; wb_exc = 6'd0; wb_csr_op = 2'd0;
    sample();
    chk("ine_rv", redirect_valid, 1'b1);
    chk("ine_rpc", redirect_pc, 32'h1c00_8000);
    accept_and_drain("ine");

    // Interrupt with ertn committing: interrupt overrides ertn
    tick();
    wb_valid = 1'b1; has_int = 1'b1; wb_ertn = 1'b1; ex_ra = 32'h1c00_0200;
    sample();
    chk("int_ex", wb_ex, 1'b1);
    chk("int_ecode", wb_ecode, 6'h00);
    chk("int_ertn", ertn_flush, 1'b0);
    tick();
    wb_valid = 1'b0; has_int = 1'b0; wb_ertn = 1'b0;
    sample();
    chk("int_rpc", redirect_pc, 32'h1c00_8000);
    accept_and_drain("int");

    // Priority sweep
    exc_case("adef", 6'b111111, 6'h08, 9'h0);
    exc_case("sys",  6'b001100, 6'h0b, 9'h0);
    exc_case("brk",  6'b011000, 6'h0c, 9'h0);
    exc_case("ale",  6'b110000, 6'h09, 9'h0);
    exc_case("adem", 6'b100000, 6'h08, 9'h1);

    // ertn alone, redirect stalled 5 cycles with next instruction waiting
    tick();
    wb_valid = 1'b1; wb_ertn = 1'b1; ex_ra = 32'h1c00_0200;
    sample();
    chk("ertn_flush", ertn_flush, 1'b1);
    chk("ertn_ex", wb_ex, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      sample();
      chk("stall_rv", redirect_valid, 1'b1);
      chk("stall_ready", wb_ready, 1'b0);
      chk("stall_ertn", ertn_flush, 1'b0);
      chk("stall_rpc", redirect_pc, 32'h1c00_0200);
    end
    wb_valid = 1'b0; wb_ertn = 1'b0;
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0; has_int = 1'b1; wb_valid = 1'b1;
    sample();
    chk("drain_rv", redirect_valid, 1'b0);
    chk("drain_flush", flush, 1'b1);
    chk("drain_int_ignored", wb_ex, 1'b0);
    chk("drain_busy", wb_ready, 1'b0);
    has_int = 1'b0; wb_valid = 1'b0;
    tick();
    tick();
    sample();
    chk("ertn_done_flush", flush, 1'b0);
    chk("ertn_done_ready", wb_ready, 1'b1);
`ifdef CSR_COMMIT_CTRL_EXC_CNT_EN
    chk("exc_count", exc_count, 32'd7);
    chk("ertn_count", ertn_count, 32'd1);
`endif

    // Reset while a redirect is pending
    tick();
    wb_valid = 1'b1; wb_csr_op = 2'd2; wb_csr_num = 14'h044; wb_pc = 32'h1c00_0400;
    sample();
    chk("ticlr_we", csr_we, 1'b1);
    tick();
    wb_valid = 1'b0; wb_csr_op = 2'd0;
    sample();
    chk("ticlr_rv", redirect_valid, 1'b1);
    chk("ticlr_rpc", redirect_pc, 32'h1c00_0404);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rv", redirect_valid, 1'b0);
    chk("async_flush", flush, 1'b0);
    chk("async_rpc", redirect_pc, 32'd0);
    tick();
    reset = 1'b0;
    sample();
    chk("post_rst_ready", wb_ready, 1'b1);
    chk("post_rst_rv", redirect_valid, 1'b0);
    chk("post_rst_flush", flush, 1'b0);
`ifdef CSR_COMMIT_CTRL_EXC_CNT_EN
    chk("exc_count_rst", exc_count, 32'd0);
    chk("ertn_count_rst", ertn_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
